// File: rtl/regbank_if.sv
// regbank_if -- register-bank access bus.
//
// Groups the selector/write/read signals of the register bank so the
// datapath sees a single port. The master side (sequencer or testbench)
// drives selectors, write controls and write data; the slave side (the
// bank) returns the two read buses and the ready flag.
//
// Parameters:
//   WIDTH  data width of w, a, b
//   SELW   selector width, log2 of the architectural register count
//
// Signals:
//   sela, selb   read selectors; selb is also the write target
//   we, bytew    write enable, low-byte-only write
//   pc_inc       request PC := PC + 2
//   mode         SP bank select (0 kernel, 1 user)
//   w            write data
//   a, b         read data for sela / selb
//   ready        bank has finished its clear sequence
interface regbank_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [SELW-1:0]  sela;
    logic [SELW-1:0]  selb;
    logic             we;
    logic             bytew;
    logic             pc_inc;
    logic             mode;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;

    modport master (
        output sela, selb, we, bytew, pc_inc, mode, w,
        input  a, b, ready
    );

    modport slave (
        input  sela, selb, we, bytew, pc_inc, mode, w,
        output a, b, ready
    );
endinterface

// File: rtl/regbank.sv
// regbank -- architectural register file with PC and banked SP.
//
// Holds NREGS general registers plus a second stack pointer. Index
// NREGS-1 is the PC, index NREGS-2 is the SP, which resolves to the
// kernel copy (mode = 0) or the user copy (mode = 1, stored in the extra
// entry at index NREGS). Reads are combinational on two ports; one write
// port targets selb. The PC has its own +2 incrementer.
//
// After reset the bank walks a clear sequence, zeroing one entry per
// clock, and only then raises ready. Until ready, both read ports return
// zero and writes / increments are ignored, so stale contents never leak.
//
// Optional feature, macro REGBANK_BYPASS_EN:
//   when defined, a read port whose resolved index matches the active
//   write index returns the value being written (after byte merge and PC
//   bit-0 forcing) in the same cycle. When undefined, reads see stored
//   values only.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset
//   bus    regbank_if.slave (sela, selb, we, bytew, pc_inc, mode, w in;
//          a, b, ready out)
module regbank #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic      clk,
    input  logic      reset,
    regbank_if.slave  bus
);
    localparam int SELW   = $clog2(NREGS);
    // One extra index bit so the user-SP entry (index NREGS) is addressable.
    localparam int IDXW   = SELW + 1;
    localparam int PC_IDX = NREGS - 1;
    localparam int SP_IDX = NREGS - 2;
    localparam int USP_IDX = NREGS;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  cnt;
    logic             ready_q;

    logic [WIDTH-1:0] mem [NREGS+1];

    // Map an architectural selector onto a storage index, applying SP banking.
    function automatic logic [IDXW-1:0] resolve(input logic [SELW-1:0] sel,
                                                input logic            m);
        if (sel == SELW'(SP_IDX) && m)
            return IDXW'(USP_IDX);
        else
            return {1'b0, sel};
    endfunction

    logic [IDXW-1:0]  idx_a;
    logic [IDXW-1:0]  idx_b;
    logic [IDXW-1:0]  widx;
    logic             wr_pc;
    logic [WIDTH-1:0] wdata;
    logic             wr_act;
    logic             inc_act;

    assign idx_a = resolve(bus.sela, bus.mode);
    assign idx_b = resolve(bus.selb, bus.mode);
    assign widx  = idx_b;
    assign wr_pc = (widx == IDXW'(PC_IDX));

    assign wr_act  = ready_q && bus.we;
    // A same-cycle write to the PC takes priority over the increment.
    assign inc_act = ready_q && bus.pc_inc && !(bus.we && wr_pc);

    // Post-write value: optional byte merge with the stored entry, then
    // force the PC even.
    always_comb begin
        wdata = bus.w;
        if (bus.bytew)
            wdata = {mem[widx][WIDTH-1:8], bus.w[7:0]};
        if (wr_pc)
            wdata[0] = 1'b0;
    end

    // Control FSM and storage updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[cnt] <= '0;
                    if (cnt == IDXW'(USP_IDX)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (wr_act)
                        mem[widx] <= wdata;
                    if (inc_act)
                        mem[PC_IDX] <= mem[PC_IDX] + WIDTH'(2);
                end
                default: begin
                    state   <= CLEAR;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Read ports. Gated to zero until the clear sequence has finished.
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (ready_q) begin
            rd_a = mem[idx_a];
            rd_b = mem[idx_b];
`ifdef REGBANK_BYPASS_EN
            if (wr_act && idx_a == widx)
                rd_a = wdata;
            if (wr_act && idx_b == widx)
                rd_b = wdata;
`endif
        end
    end

    assign bus.a     = rd_a;
    assign bus.b     = rd_b;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_regbank.sv
// tb_regbank -- directed self-checking bench for regbank (WIDTH 16, NREGS 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_regbank;
    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int SELW  = 3;
    localparam int PC    = 7;
    localparam int SP    = 6;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total    = 0;

    regbank_if #(.WIDTH(WIDTH), .SELW(SELW)) bus();

    regbank #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we     = 1'b0;
        bus.bytew  = 1'b0;
        bus.pc_inc = 1'b0;
    endtask

    // One clocked write, leaving the controls idle afterwards.
    task automatic wr(input int sel, input logic [WIDTH-1:0] val,
                      input logic bw, input logic m);
        bus.selb  = SELW'(sel);
        bus.w     = val;
        bus.bytew = bw;
        bus.mode  = m;
        bus.we    = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic ok;
        reset = 1'b1;
        idle();
        bus.sela = 3'd5;
        bus.selb = 3'd7;
        bus.mode = 1'b0;
        bus.w    = 16'h0000;
        repeat (3) begin
            tick();
            total++;
            if (bus.ready !== 1'b0 || bus.a !== 16'h0 || bus.b !== 16'h0)
                $display("FAIL reset_hold ready=%b a=%h b=%h want 0/0/0", bus.ready, bus.a, bus.b);
            else pass_cnt++;
        end
        // Writes and increments during the clear walk must be ignored.
        bus.we = 1'b1; bus.selb = 3'd0; bus.w = 16'h1234; bus.pc_inc = 1'b1;
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.ready !== 1'b0 || bus.a !== 16'h0 || bus.b !== 16'h0) ok = 1'b0;
        end
        total++;
        if (!ok) $display("FAIL clear_walk ready/a/b not zero during 8 clear edges");
        else pass_cnt++;
        idle();
        tick();
        total++;
        if (bus.ready !== 1'b1) $display("FAIL clear_done ready=%b want 1", bus.ready);
        else pass_cnt++;
        for (int i = 0; i < NREGS; i++) begin
            bus.sela = SELW'(i);
            bus.selb = SELW'(i);
            bus.mode = 1'b0;
            #1;
            total++;
            if (bus.a !== 16'h0 || bus.b !== 16'h0)
                $display("FAIL cleared_r%0d a=%h b=%h want 0", i, bus.a, bus.b);
            else pass_cnt++;
        end
        bus.sela = SELW'(SP);
        bus.mode = 1'b1;
        #1;
        total++;
        if (bus.a !== 16'h0) $display("FAIL cleared_usp a=%h want 0", bus.a);
        else pass_cnt++;
        bus.mode = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        logic ok;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus.ready !== 1'b0) $display("FAIL midclear_reset ready=%b want 0", bus.ready);
        else pass_cnt++;
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.ready !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) $display("FAIL midclear_restart ready rose before 9th edge");
        else pass_cnt++;
        tick();
        total++;
        if (bus.ready !== 1'b1) $display("FAIL midclear_done ready=%b want 1", bus.ready);
        else pass_cnt++;
    endtask

    task automatic test_byte_pc();
        wr(3, 16'o177777, 1'b0, 1'b0);
        wr(3, 16'o000102, 1'b1, 1'b0);
        bus.sela = 3'd3;
        #1;
        total++;
        if (bus.a !== 16'o177502) $display("FAIL byte_write got %o want %o", bus.a, 16'o177502);
        else pass_cnt++;
        wr(PC, 16'o1001, 1'b0, 1'b0);
        bus.sela = SELW'(PC);
        #1;
        total++;
        if (bus.a !== 16'o1000) $display("FAIL pc_write_bit0 got %o want %o", bus.a, 16'o1000);
        else pass_cnt++;
    endtask

    task automatic test_pc_inc();
        wr(PC, 16'o177776, 1'b0, 1'b0);
        bus.pc_inc = 1'b1;
        tick();
        idle();
        bus.sela = SELW'(PC);
        #1;
        total++;
        if (bus.a !== 16'h0) $display("FAIL pc_wrap got %o want 0", bus.a);
        else pass_cnt++;
        bus.pc_inc = 1'b1;
        wr(PC, 16'o400, 1'b0, 1'b0);
        total++;
        if (bus.a !== 16'o400) $display("FAIL pc_collision got %o want %o", bus.a, 16'o400);
        else pass_cnt++;
        bus.pc_inc = 1'b1;
        tick();
        idle();
        total++;
        if (bus.a !== 16'o402) $display("FAIL pc_inc got %o want %o", bus.a, 16'o402);
        else pass_cnt++;
    endtask

    task automatic test_sp_bank();
        wr(SP, 16'o1000, 1'b0, 1'b0);
        wr(SP, 16'o2000, 1'b0, 1'b1);
        bus.sela = SELW'(SP);
        bus.mode = 1'b0;
        #1;
        total++;
        if (bus.a !== 16'o1000) $display("FAIL sp_kernel got %o want %o", bus.a, 16'o1000);
        else pass_cnt++;
        bus.mode = 1'b1;
        #1;
        total++;
        if (bus.a !== 16'o2000) $display("FAIL sp_user got %o want %o", bus.a, 16'o2000);
        else pass_cnt++;
        bus.mode = 1'b0;
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_same;
        wr(2, 16'o55, 1'b0, 1'b0);
`ifdef REGBANK_BYPASS_EN
        exp_same = 16'o123;
`else
        exp_same = 16'o55;
`endif
        bus.sela = 3'd2;
        bus.selb = 3'd2;
        bus.w    = 16'o123;
        bus.we   = 1'b1;
        #1;
        total++;
        if (bus.a !== exp_same) $display("FAIL bypass_same_cycle got %o want %o", bus.a, exp_same);
        else pass_cnt++;
        tick();
        idle();
        total++;
        if (bus.a !== 16'o123) $display("FAIL bypass_next_cycle got %o want %o", bus.a, 16'o123);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_byte_pc();
        test_pc_inc();
        test_sp_bank();
        test_bypass();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/regbank.md
REGBANK -- requirements
Module: regbank

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of every register and bus; legal values are 8 to 32.
REQ-002 Parameter NREGS, default 8, SHALL set the architectural register count; it is a power of two and at least 4.
REQ-003 Derived SELW = log2(NREGS) SHALL set the selector width; PC is index NREGS-1 and SP is index NREGS-2.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 sela  input  SELW  SHALL select the register driven on bus a.
REQ-007 selb  input  SELW  SHALL select the register driven on bus b and the write target.
REQ-008 we  input  1  SHALL be the write enable for R[selb].
REQ-009 bytew  input  1  SHALL select a byte write, meaning only bits 7:0 are written.
REQ-010 pc_inc  input  1  SHALL request PC := PC + 2.
REQ-011 mode  input  1  SHALL select the SP bank: 0 is kernel SP and 1 is user SP.
REQ-012 w  input  WIDTH  SHALL be the write data.
REQ-013 a  output  WIDTH  SHALL be the read data for sela.
REQ-014 b  output  WIDTH  SHALL be the read data for selb.
REQ-015 ready  output  1  SHALL be high once the clear sequence is complete.

Function
REQ-016 Storage SHALL hold NREGS+1 entries: R0..R(NREGS-1) plus a second SP; index NREGS-2 resolves to the kernel or user SP according to mode, for both reads and writes.
REQ-017 Reads SHALL be combinational: a = R[sela] and b = R[selb], subject to mode banking and REQ-025.
REQ-018 Both a and b SHALL read 0 while ready = 0.
REQ-019 Write: at a rising edge with ready = 1 and we = 1, R[selb] SHALL take w; when bytew = 1, only bits 7:0 are updated and bits WIDTH-1:8 are preserved.
REQ-020 Any write to the PC SHALL force bit 0 to 0.
REQ-021 pc_inc: at a rising edge with ready = 1, PC SHALL take (PC + 2) mod 2^WIDTH, wrapping from max-1 to 0.
REQ-022 When we = 1 with selb = PC and pc_inc = 1 in the same cycle, the write SHALL win and the increment SHALL be dropped.
REQ-023 When ready = 0, we and pc_inc SHALL be ignored.
REQ-024 State machine SHALL have two states, CLEAR and RUN:
- CLEAR: a counter cnt (0..NREGS) zeroes entry cnt on each edge with reset low, then increments.
- After entry NREGS is cleared, the block moves to RUN.
- ready = 1 exactly in RUN.

Reset
REQ-026 reset = 1 at a rising edge SHALL force state CLEAR, cnt = 0, and ready = 0, from either state, including mid-clear.
REQ-027 While reset is held high, cnt SHALL remain 0 and no entry is cleared.
REQ-028 ready SHALL rise on the (NREGS+1)th rising edge after the first edge with reset low; by then all NREGS+1 entries are 0.
REQ-029 Register contents before clear completion SHALL be unobservable, because of REQ-018.

Configuration
REQ-025 With macro REGBANK_BYPASS_EN defined, and with ready = 1 and we = 1, any read port whose resolved index equals the write index SHALL show the post-write value combinationally in the same cycle (byte merge and PC bit-0 rule applied). Without the macro, reads SHALL show only stored values, and the new value is visible the cycle after the edge.
REQ-030 The macro SHALL affect only REQ-025; all other behaviour is identical in both builds.

Verification
REQ-031 Clear sequence (NREGS = 8): hold reset 3 cycles, then release -> ready = 0 and a = b = 0 for 8 edges, ready = 1 after the 9th edge, and every register reads 0.
REQ-032 Reset mid-clear: assert reset at clear step 4 -> cnt restarts and ready rises 9 edges after the re-release.
REQ-033 Byte write and PC write:
- R3 = 0o177777, then we = 1, bytew = 1, w = 0o000102 -> R3 = 0o177502.
- Write PC with w = 0o1001 -> PC = 0o1000.
REQ-034 PC increment and collision:
- PC = 0o177776 with pc_inc -> PC = 0.
- Same cycle we to PC (w = 0o400) and pc_inc -> PC = 0o400.
REQ-035 SP banking: mode = 0 write SP = 0o1000, then mode = 1 write SP = 0o2000 -> reading SP gives 0o1000 with mode = 0 and 0o2000 with mode = 1.
REQ-036 Bypass: sela = selb = 2, we = 1, w = 0o123 -> a = 0o123 in the same cycle with REGBANK_BYPASS_EN, and the old value without it.
